// File: rtl/stage_memory_if.sv
// Data-memory bus between the memory-access stage and data memory.
// Wait-request / read-data-valid handshake, one request in flight.
interface stage_memory_if;
  logic [15:0] o_mem_addr;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [15:0] o_mem_wrdata;
  logic        i_mem_waitrequest;
  logic        i_mem_readdatavalid;
  logic [15:0] i_mem_rddata;

  modport master (
    output o_mem_addr, o_mem_read, o_mem_write, o_mem_wrdata,
    input  i_mem_waitrequest, i_mem_readdatavalid, i_mem_rddata
  );

  modport slave (
    input  o_mem_addr, o_mem_read, o_mem_write, o_mem_wrdata,
    output i_mem_waitrequest, i_mem_readdatavalid, i_mem_rddata
  );
endinterface

// File: rtl/stage_memory.sv
// Memory-access pipeline stage: holds one instruction, performs LD/ST over the
// data-memory handshake, stalls upstream while the access is outstanding.
module stage_memory (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [15:0] ex_ir,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic        ex_z,
  input  logic        ex_n,
  output logic        stall,
  stage_memory_if.master mem,
  output logic        wb_valid,
  output logic [15:0] wb_ir,
  output logic [15:0] wb_alu_reg,
  output logic [15:0] wb_mem_data,
  output logic        wb_z,
  output logic        wb_n
);

  localparam logic [3:0] OP_LD = 4'b0100;
  localparam logic [3:0] OP_ST = 4'b0101;

  typedef enum logic [0:0] {RUN = 1'b0, DATA_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        m_valid_q, m_z_q, m_n_q;
  logic [15:0] m_ir_q, m_alu_q, m_sdata_q;
  logic        wb_valid_q, wb_z_q, wb_n_q;
  logic [15:0] wb_ir_q, wb_alu_q, wb_mem_data_q;

  logic is_ld, is_st;
  logic mem_rd, mem_wr, advance, ld_done, stall_s;

  assign is_ld = m_valid_q && (m_ir_q[3:0] == OP_LD);
  assign is_st = m_valid_q && (m_ir_q[3:0] == OP_ST);

  // Access sequencing: advance means the held instruction moves to writeback.
  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    advance = 1'b0;
    ld_done = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (is_ld) begin
          mem_rd  = 1'b1;
          stall_s = 1'b1;
          if (!mem.i_mem_waitrequest) begin
            state_d = DATA_WAIT;
          end else begin
            state_d = RUN;
          end
        end else if (is_st) begin
          mem_wr = 1'b1;
          if (!mem.i_mem_waitrequest) begin
            advance = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      DATA_WAIT: begin
        if (mem.i_mem_readdatavalid) begin
          advance = 1'b1;
          ld_done = 1'b1;
          state_d = RUN;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // A flush abandons whatever access is in progress in the same cycle.
    if (flush) begin
      state_d = RUN;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      advance = 1'b0;
      ld_done = 1'b0;
      stall_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // M register: captures the execute bundle whenever the stage is not stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      m_ir_q    <= 16'h0000;
      m_alu_q   <= 16'h0000;
      m_sdata_q <= 16'h0000;
      m_z_q     <= 1'b0;
      m_n_q     <= 1'b0;
    end else if (!stall_s) begin
      m_valid_q <= ex_valid & ~flush;
      m_ir_q    <= ex_ir;
      m_alu_q   <= ex_alu_out;
      m_sdata_q <= ex_store_data;
      m_z_q     <= ex_z;
      m_n_q     <= ex_n;
    end
  end

  // Writeback bundle: updated on completion, bubble while stalled or flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q    <= 1'b0;
      wb_ir_q       <= 16'h0000;
      wb_alu_q      <= 16'h0000;
      wb_mem_data_q <= 16'h0000;
      wb_z_q        <= 1'b0;
      wb_n_q        <= 1'b0;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
    end else if (advance) begin
      wb_valid_q <= m_valid_q;
      wb_ir_q    <= m_ir_q;
      wb_alu_q   <= m_alu_q;
      wb_z_q     <= m_z_q;
      wb_n_q     <= m_n_q;
      if (ld_done) begin
        wb_mem_data_q <= mem.i_mem_rddata;
      end
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  assign stall            = stall_s;
  assign mem.o_mem_addr   = m_alu_q;
  assign mem.o_mem_wrdata = m_sdata_q;
  assign mem.o_mem_read   = mem_rd;
  assign mem.o_mem_write  = mem_wr;

  assign wb_valid    = wb_valid_q;
  assign wb_ir       = wb_ir_q;
  assign wb_alu_reg  = wb_alu_q;
  assign wb_mem_data = wb_mem_data_q;
  assign wb_z        = wb_z_q;
  assign wb_n        = wb_n_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: hand-computed expectations checked with
// immediate assertions one step after each rising edge.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ex_valid;
  logic [15:0] ex_ir, ex_alu_out, ex_store_data;
  logic        ex_z, ex_n;
  logic        stall;
  logic        wb_valid, wb_z, wb_n;
  logic [15:0] wb_ir, wb_alu_reg, wb_mem_data;

  int errors = 0;
  int checks = 0;

  stage_memory_if mem ();

  stage_memory dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ir         (ex_ir),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_z          (ex_z),
    .ex_n          (ex_n),
    .stall         (stall),
    .mem           (mem.master),
    .wb_valid      (wb_valid),
    .wb_ir         (wb_ir),
    .wb_alu_reg    (wb_alu_reg),
    .wb_mem_data   (wb_mem_data),
    .wb_z          (wb_z),
    .wb_n          (wb_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [15:0] ir, input logic [15:0] alu,
                        input logic [15:0] sd, input logic z, input logic n);
    ex_valid = v; ex_ir = ir; ex_alu_out = alu; ex_store_data = sd; ex_z = z; ex_n = n;
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    set_ex(1'b1, 16'h0021, 16'h1234, 16'h0000, 1'b0, 1'b0);
    mem.i_mem_waitrequest   = 1'b0;
    mem.i_mem_readdatavalid = 1'b0;
    mem.i_mem_rddata        = 16'h0000;

    // Reset held with a valid bundle at the input
    repeat (3) tick();
    #1;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_read", {15'd0, mem.o_mem_read}, 16'd0);
    chk("rst_write", {15'd0, mem.o_mem_write}, 16'd0);
    chk("rst_addr", mem.o_mem_addr, 16'h0000);
    chk("rst_wrdata", mem.o_mem_wrdata, 16'h0000);
    chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("rst_wb_ir", wb_ir, 16'h0000);

    reset_n = 1'b1;
    tick();                                   // M <= ADD
    chk("add_m_addr", mem.o_mem_addr, 16'h1234);
    chk("add_nostall", {15'd0, stall}, 16'd0);
    chk("add_wb_notyet", {15'd0, wb_valid}, 16'd0);
    set_ex(1'b1, 16'h0004, 16'h0040, 16'h0000, 1'b0, 1'b0);

    // LD, no wait, data one cycle after accept
    tick();                                   // wb <= ADD, M <= LD
    chk("add_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("add_wb_ir", wb_ir, 16'h0021);
    chk("add_wb_alu", wb_alu_reg, 16'h1234);
    chk("ld_read", {15'd0, mem.o_mem_read}, 16'd1);
    chk("ld_stall1", {15'd0, stall}, 16'd1);
    chk("ld_addr", mem.o_mem_addr, 16'h0040);
    set_ex(1'b1, 16'h0031, 16'h1111, 16'h0000, 1'b0, 1'b0);
    tick();                                   // accepted -> DATA_WAIT
    chk("ld_read_drop", {15'd0, mem.o_mem_read}, 16'd0);
    chk("ld_stall2", {15'd0, stall}, 16'd1);
    chk("ld_bubble", {15'd0, wb_valid}, 16'd0);
    mem.i_mem_readdatavalid = 1'b1;
    mem.i_mem_rddata        = 16'hBEEF;
    #1;
    chk("ld_done_nostall", {15'd0, stall}, 16'd0);
    tick();                                   // wb <= LD, M <= ADD2
    mem.i_mem_readdatavalid = 1'b0;
    mem.i_mem_rddata        = 16'h0000;
    #1;
    chk("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("ld_wb_ir", wb_ir, 16'h0004);
    chk("ld_wb_data", wb_mem_data, 16'hBEEF);
    chk("add2_nostall", {15'd0, stall}, 16'd0);
    set_ex(1'b1, 16'h0005, 16'h0080, 16'h5A5A, 1'b0, 1'b0);

    // ST with three waitrequest cycles
    tick();                                   // wb <= ADD2, M <= ST
    mem.i_mem_waitrequest = 1'b1;
    #1;
    chk("add2_wb_ir", wb_ir, 16'h0031);
    chk("st_write0", {15'd0, mem.o_mem_write}, 16'd1);
    chk("st_stall0", {15'd0, stall}, 16'd1);
    set_ex(1'b1, 16'h0041, 16'h2222, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_write_w", {15'd0, mem.o_mem_write}, 16'd1);
      chk("st_stall_w", {15'd0, stall}, 16'd1);
      chk("st_addr_w", mem.o_mem_addr, 16'h0080);
      chk("st_data_w", mem.o_mem_wrdata, 16'h5A5A);
      chk("st_bubble_w", {15'd0, wb_valid}, 16'd0);
    end
    tick();
    mem.i_mem_waitrequest = 1'b0;
    #1;
    chk("st_write_last", {15'd0, mem.o_mem_write}, 16'd1);
    chk("st_stall_last", {15'd0, stall}, 16'd0);
    chk("st_bubble3", {15'd0, wb_valid}, 16'd0);
    tick();                                   // wb <= ST, M <= ADD3
    chk("st_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("st_wb_ir", wb_ir, 16'h0005);
    chk("st_wb_data_hold", wb_mem_data, 16'hBEEF);
    chk("st_write_off", {15'd0, mem.o_mem_write}, 16'd0);
    set_ex(1'b1, 16'h0004, 16'h0044, 16'h0000, 1'b0, 1'b0);

    // Flush in the first M cycle of a LD
    tick();                                   // wb <= ADD3, M <= LD2
    chk("add3_wb_ir", wb_ir, 16'h0041);
    flush = 1'b1;
    set_ex(1'b1, 16'h0051, 16'h3333, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("flush_read", {15'd0, mem.o_mem_read}, 16'd0);
    chk("flush_stall", {15'd0, stall}, 16'd0);
    tick();                                   // LD2 squashed, ADD4 loaded invalid
    flush = 1'b0;
    set_ex(1'b1, 16'h0004, 16'h0048, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("flush_wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("flush_after_read", {15'd0, mem.o_mem_read}, 16'd0);
    tick();                                   // wb <= squashed slot, M <= LD3
    chk("flush_no_ld_pulse", {15'd0, wb_valid}, 16'd0);
    chk("ld3_read", {15'd0, mem.o_mem_read}, 16'd1);
    chk("ld3_addr", mem.o_mem_addr, 16'h0048);
    set_ex(1'b1, 16'h0015, 16'h0090, 16'h1357, 1'b0, 1'b1);

    // LD followed by ST, ex held under stall
    tick();                                   // DATA_WAIT
    chk("ldst_stall", {15'd0, stall}, 16'd1);
    chk("ldst_addr_hold", mem.o_mem_addr, 16'h0048);
    chk("ldst_no_write", {15'd0, mem.o_mem_write}, 16'd0);
    mem.i_mem_readdatavalid = 1'b1;
    mem.i_mem_rddata        = 16'hCAFE;
    tick();                                   // wb <= LD3, M <= ST2
    mem.i_mem_readdatavalid = 1'b0;
    mem.i_mem_rddata        = 16'h0000;
    #1;
    chk("ldst_ld_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("ldst_ld_wb_ir", wb_ir, 16'h0004);
    chk("ldst_ld_data", wb_mem_data, 16'hCAFE);
    chk("ldst_st_write", {15'd0, mem.o_mem_write}, 16'd1);
    chk("ldst_st_addr", mem.o_mem_addr, 16'h0090);
    chk("ldst_st_data", mem.o_mem_wrdata, 16'h1357);
    chk("ldst_st_nostall", {15'd0, stall}, 16'd0);
    set_ex(1'b1, 16'h0071, 16'h5555, 16'h0000, 1'b1, 1'b0);
    tick();                                   // wb <= ST2, M <= ADD6
    chk("ldst_st_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("ldst_st_wb_ir", wb_ir, 16'h0015);
    chk("ldst_st_wb_alu", wb_alu_reg, 16'h0090);
    chk("ldst_st_wb_n", {15'd0, wb_n}, 16'd1);
    chk("ldst_st_data_hold", wb_mem_data, 16'hCAFE);

    // readdatavalid while in RUN is ignored
    mem.i_mem_readdatavalid = 1'b1;
    mem.i_mem_rddata        = 16'hDEAD;
    #1;
    chk("rdv_run_stall", {15'd0, stall}, 16'd0);
    tick();                                   // wb <= ADD6
    chk("rdv_run_wb_valid", {15'd0, wb_valid}, 16'd1);
    chk("rdv_run_wb_z", {15'd0, wb_z}, 16'd1);
    chk("rdv_run_data", wb_mem_data, 16'hCAFE);
    tick();
    mem.i_mem_readdatavalid = 1'b0;
    #1;
    chk("rdv_run_data2", wb_mem_data, 16'hCAFE);
    chk("rdv_run_noread", {15'd0, mem.o_mem_read}, 16'd0);
    set_ex(1'b1, 16'h0004, 16'h004C, 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a LD request
    tick();                                   // M <= LD4
    chk("ld4_read", {15'd0, mem.o_mem_read}, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_read", {15'd0, mem.o_mem_read}, 16'd0);
    chk("rst_mid_stall", {15'd0, stall}, 16'd0);
    chk("rst_mid_wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("rst_mid_data", wb_mem_data, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
